// File: rtl/uart_tx_arb_if.sv
// Bundle of the requester-side and uart_tx-side AXI-stream signals of uart_tx_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface uart_tx_arb_if #(
  parameter int N_REQ = 4,
  parameter int W_OUT = 16,
  parameter int W_ID  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]            s_valid;
  logic [N_REQ-1:0]            s_ready;
  logic [N_REQ-1:0][W_OUT-1:0] s_data;
  logic                        m_valid;
  logic                        m_ready;
  logic [W_OUT-1:0]            m_data;
  logic [W_ID-1:0]             m_id;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_id
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_id
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between N_REQ AXI-stream producers, one whole word at a time.
// Optional macro UART_TX_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module uart_tx_arb #(
  parameter int N_REQ = 4,
  parameter int W_OUT = 16,
  parameter int W_ID  = $clog2(N_REQ)
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_arb_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W_ID-1:0]  last_grant;
  logic [W_ID-1:0]  grant;
  logic             found;
  logic             prio_grant;
  logic             load;
  logic [N_REQ-1:0] s_ready_c;
  logic             m_valid;
  logic [W_OUT-1:0] m_data;
  logic [W_ID-1:0]  m_id;

  // Search starts just after the last round-robin winner, so index N_REQ-1 wraps to 0.
  always_comb begin
    grant      = '0;
    found      = 1'b0;
    prio_grant = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && bus.s_valid[(int'(last_grant) + k) % N_REQ]) begin
        grant = W_ID'((int'(last_grant) + k) % N_REQ);
        found = 1'b1;
      end
    end
`ifdef UART_TX_ARB_PRIO0_EN
    if (bus.s_valid[0]) begin
      grant      = '0;
      found      = 1'b1;
      prio_grant = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    s_ready_c = '0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          s_ready_c[grant] = 1'b1;
          load             = 1'b1;
          state_nxt        = SEND;
        end
      end
      SEND: begin
        if (m_valid && bus.m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A word is captured on the requester handshake and held until uart_tx takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= W_ID'(N_REQ - 1);
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_id       <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= bus.s_data[grant];
        m_id    <= grant;
        if (!prio_grant) last_grant <= grant;
      end else if (state == SEND && bus.m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_data;
  assign bus.m_id    = m_id;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (N_REQ=4, W_OUT=16) against a transaction-level arbiter model.
module tb_uart_tx_arb;

`ifdef UART_TX_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   errors;
  int   checks;

  uart_tx_arb_if #(.N_REQ(4), .W_OUT(16)) bus ();

  uart_tx_arb #(.N_REQ(4), .W_OUT(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "busy" holds one committed word; rr_last is the last round-robin winner.
  bit          mb;
  logic [15:0] md;
  int          mid;
  int          rr_last;

  function automatic int pick(logic [3:0] v, int last);
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int p;
    p = pick(bus.s_valid, rr_last);
    if (mb || p < 0) return 4'b0000;
    return 4'(1 << p);
  endfunction

  task automatic model_reset();
    mb = 1'b0; md = 16'h0; mid = 0; rr_last = 3;
  endtask

  task automatic model_edge();
    int p;
    if (!mb) begin
      p = pick(bus.s_valid, rr_last);
      if (p >= 0) begin
        mb  = 1'b1;
        md  = bus.s_data[p];
        mid = p;
        if (!(PRIO && p == 0)) rr_last = p;
      end
    end else if (bus.m_ready) begin
      mb = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 16'h0 || bus.m_id !== 2'd0 || bus.s_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset: m_valid=%b m_data=%h m_id=%0d s_ready=%b, required 0/0000/0/0000",
               bus.m_valid, bus.m_data, bus.m_id, bus.s_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    bus.s_valid = 4'b0100; bus.s_data[2] = 16'hA55A; bus.m_ready = 1'b1;
    #1; checks++;
    if (bus.s_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b required 0100", bus.s_ready);
    end
    model_edge(); @(negedge clk);
    bus.s_valid = 4'b0000;
    #1; checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'hA55A || bus.m_id !== 2'd2 || bus.s_ready !== 4'b0) begin
      errors++;
      $display("FAIL single_out: m_valid=%b m_data=%h m_id=%0d s_ready=%b, required 1/a55a/2/0000",
               bus.m_valid, bus.m_data, bus.m_id, bus.s_ready);
    end
    model_edge(); @(negedge clk);
    #1; checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL single_drop: m_valid=%b required 0", bus.m_valid);
    end
    model_edge(); @(negedge clk);
  endtask

  task automatic test_all_valid();
    logic [15:0] got[$];
    logic [15:0] want [6];
    do_reset();
    for (int i = 0; i < 4; i++) bus.s_data[i] = 16'(16'h1000 + i);
    bus.s_valid = 4'hF; bus.m_ready = 1'b1;
    if (PRIO) want = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
    else      want = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1000, 16'h1001};
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      checks++;
      if (bus.s_ready !== exp_ready()) begin
        errors++; $display("FAIL all_valid_ready c%0d: got %b required %b", c, bus.s_ready, exp_ready());
      end
      model_edge(); @(negedge clk);
    end
    checks++;
    if (got.size() != 6) begin
      errors++; $display("FAIL all_valid_count: got %0d words required 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++; $display("FAIL all_valid_seq[%0d]: got %h required %h", i, got[i], want[i]);
      end
    end
    bus.s_valid = '0;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    bus.s_valid = 4'b0010; bus.s_data[1] = 16'hBEEF; bus.m_ready = 1'b0;
    #1; model_edge(); @(negedge clk);
    bus.s_valid = 4'b1101;
    bus.s_data[0] = 16'h1111; bus.s_data[2] = 16'h2222; bus.s_data[3] = 16'h3333;
    for (int c = 0; c < 50; c++) begin
      #1; checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 16'hBEEF || bus.m_id !== 2'd1 || bus.s_ready !== 4'b0) begin
        errors++;
        $display("FAIL backpressure c%0d: m_valid=%b m_data=%h m_id=%0d s_ready=%b, required 1/beef/1/0000",
                 c, bus.m_valid, bus.m_data, bus.m_id, bus.s_ready);
      end
      model_edge(); @(negedge clk);
    end
    bus.s_valid = '0; bus.m_ready = 1'b1; n = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.m_valid && bus.m_ready) n++;
      model_edge(); @(negedge clk);
    end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL backpressure_release: got %0d transfers required 1", n);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] want;
    do_reset();
    bus.s_valid = 4'b1000; bus.s_data[3] = 16'h0033;
    #1; checks++;
    if (bus.s_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_g3: got %b required 1000", bus.s_ready);
    end
    model_edge(); @(negedge clk);
    bus.s_valid = 4'b0000; bus.m_ready = 1'b1;
    #1; model_edge(); @(negedge clk);
    bus.s_valid = 4'b0010;
    #1; checks++;
    if (bus.s_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_g1: got %b required 0010", bus.s_ready);
    end
    model_edge(); @(negedge clk);
    bus.s_valid = 4'b0000;
    #1; model_edge(); @(negedge clk);
    bus.s_valid = 4'b1001;
    want = PRIO ? 4'b0001 : 4'b1000;
    #1; checks++;
    if (bus.s_ready !== want) begin
      errors++; $display("FAIL wrap_3_before_0: got %b required %b", bus.s_ready, want);
    end
    model_edge(); @(negedge clk);
    bus.s_valid = '0;
    #1; model_edge(); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.s_valid = 4'b0100; bus.s_data[2] = 16'h7E57; bus.m_ready = 1'b0;
    #1; model_edge(); @(negedge clk);
    bus.s_valid = '0;
    #1; checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: m_valid=%b required 1", bus.m_valid);
    end
    rstn = 1'b0;
    #1; checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 16'h0) begin
      errors++; $display("FAIL reset_mid_async: m_valid=%b m_data=%h required 0/0000", bus.m_valid, bus.m_data);
    end
    @(negedge clk);
    rstn = 1'b1; model_reset();
    bus.s_valid = 4'b0110; bus.s_data[1] = 16'h0101; bus.m_ready = 1'b1;
    #1; checks++;
    if (bus.s_ready !== 4'b0010) begin
      errors++; $display("FAIL reset_mid_regrant: got %b required 0010", bus.s_ready);
    end
    model_edge(); @(negedge clk);
    bus.s_valid = '0;
    #1; checks++;
    if (bus.m_valid !== 1'b1 || bus.m_id !== 2'd1 || bus.m_data !== 16'h0101) begin
      errors++;
      $display("FAIL reset_mid_word: m_valid=%b m_id=%0d m_data=%h required 1/1/0101",
               bus.m_valid, bus.m_id, bus.m_data);
    end
    model_edge(); @(negedge clk);
  endtask

  task automatic test_req0_vs_2();
    int ids[$];
    do_reset();
    bus.s_valid = 4'b0101; bus.s_data[0] = 16'h00A0; bus.s_data[2] = 16'h00A2; bus.m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.m_valid && bus.m_ready) ids.push_back(int'(bus.m_id));
      model_edge(); @(negedge clk);
    end
    checks++;
    if (ids.size() != 4) begin
      errors++; $display("FAIL req0_count: got %0d words required 4", ids.size());
    end
    for (int i = 0; i < ids.size(); i++) begin
      checks++;
      if (ids[i] != (PRIO ? 0 : ((i % 2) * 2))) begin
        errors++; $display("FAIL req0_order[%0d]: got id %0d required %0d", i, ids[i], PRIO ? 0 : ((i % 2) * 2));
      end
    end
    bus.s_valid = '0;
  endtask

  task automatic test_random();
    int dut_n, mod_n;
    do_reset();
    dut_n = 0; mod_n = 0;
    for (int c = 0; c < 400; c++) begin
      bus.s_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) bus.s_data[i] = 16'($urandom);
      bus.m_ready = ($urandom % 3) != 0;
      #1; checks++;
      if (bus.s_ready !== exp_ready() || bus.m_valid !== mb ||
          (mb && (bus.m_data !== md || int'(bus.m_id) != mid))) begin
        errors++;
        $display("FAIL random c%0d: s_ready=%b m_valid=%b m_data=%h m_id=%0d required %b/%b/%h/%0d",
                 c, bus.s_ready, bus.m_valid, bus.m_data, bus.m_id, exp_ready(), mb, md, mid);
      end
      if (bus.m_valid && bus.m_ready) dut_n++;
      if (mb && bus.m_ready) mod_n++;
      model_edge(); @(negedge clk);
    end
    checks++;
    if (dut_n != mod_n || mod_n == 0) begin
      errors++; $display("FAIL random_transfers: got %0d required %0d", dut_n, mod_n);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    bus.s_valid = '0; bus.s_data = '0; bus.m_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_req0_vs_2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
